memory_port_arbiter: RTL
========================

# memory_port_arbiter

Arbitrates the single read/write port of the unified instruction/data memory between the fetch stage and the memory stage. It sits between the pipeline and the memory.
- Data accesses have priority, and a bounded starvation counter guarantees that fetch makes forward progress.
- It tracks which requester owns the response in flight and steers it back to that requester.
- It generates per-requester stalls and substitutes a NOP for any fetch that is not delivered.

## Interface
Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while fetch is waiting; the next grant is forced to fetch. Must be ≥1.
- NOP_INSTR, 32'h0000_0013: instruction returned when no valid fetch response exists.

Ports:
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- F_Req  input  1  fetch request.
- F_Addr  input  32  fetch address (PC).
- Stall_En  input  1  hazard-unit stall; suppresses fetch issue.
- Flush_D  input  1  squashes the fetch issued this cycle and the fetch response returned this cycle.
- D_Req  input  1  memory-stage load/store request.
- D_W_En  input  1  store when 1, load when 0.
- D_Control  input  3  width/sign code, passed to memory unchanged.
- D_Addr  input  32  data address.
- D_W_Data  input  32  store data.
- M_Addr  output  32  memory address.
- M_W_En  output  1  memory write enable.
- M_Control  output  3  memory width/sign code.
- M_W_Data  output  32  memory write data.
- M_R_Data  input  32  memory read data; valid one cycle after the address.
- Instr  output  32  fetched instruction to decode.
- F_Valid  output  1  Instr is a real fetch response.
- D_R_Data  output  32  load data.
- D_Done  output  1  data access completed.
- Stall_Fetch  output  1  fetch was denied; the PC must hold.
- Stall_Mem  output  1  data access was denied; the memory stage must hold.

## Operation
- Grant decision, combinational each cycle N, in priority order:
  - If Starve_Cnt == MAX_DATA_BURST and fetch is eligible (F_Req && !Stall_En): grant FETCH.
  - Else if D_Req: grant DATA.
  - Else if fetch is eligible: grant FETCH.
  - Else: grant NONE.
- Memory-side outputs by grant:
  - FETCH: M_Addr=F_Addr, M_W_En=0, M_Control=3'b010 (word).
  - DATA: M_Addr=D_Addr, M_W_En=D_W_En, M_Control=D_Control, M_W_Data=D_W_Data.
  - NONE: M_Addr=0, M_W_En=0, M_Control=0, M_W_Data=0.
- M_W_En is never high unless DATA is granted.
- Stall outputs:
  - Stall_Fetch = F_Req && !Stall_En && grant != FETCH.
  - Stall_Mem = D_Req && grant != DATA.
- Response-owner FSM (registered, holds the grant of the previous cycle):
  - IDLE: no access in flight.
  - FETCH: a fetch is in flight.
  - DATA: a data access is in flight.
  - Next state = current grant. A FETCH grant issued while Flush_D=1 is recorded as FETCH with Kill=1.
- Response steering, cycle N+1:
  - State FETCH, Kill=0 and Flush_D=0: Instr=M_R_Data, F_Valid=1.
  - Any other case: Instr=NOP_INSTR, F_Valid=0.
  - State DATA: D_Done=1. D_R_Data=M_R_Data for a load and 0 for a store (registered load flag).
  - Otherwise: D_Done=0, D_R_Data=0.
- Starve_Cnt:
  - Increments, saturating at MAX_DATA_BURST, on a cycle with a DATA grant while fetch is eligible.
  - Clears on any FETCH grant, or on any cycle where fetch is not eligible.
  - Width is $clog2(MAX_DATA_BURST+1).
- Reset (RST=1 at an edge): state IDLE, Kill=0, Starve_Cnt=0.
  - Outputs in the following cycle: Instr=NOP_INSTR, F_Valid=0, D_Done=0, D_R_Data=0.
  - An access in flight when reset is applied is discarded and produces no response.
  - While RST is high, the grant is forced to NONE, so M_W_En=0 and both stalls are 0.

## Timing
- Read latency is 1 cycle from grant to response, for both requesters.
- A store commits at the edge that ends its grant cycle; D_Done follows in the next cycle.
- Back-to-back grants are allowed every cycle with no bubble.
- D_Req and fetch eligible in the same cycle:
  - Data wins, and Stall_Fetch=1 in that cycle.
  - Exception: when Starve_Cnt == MAX_DATA_BURST, fetch wins and Stall_Mem=1.
- Flush_D timing:
  - Flush_D in cycle N kills the FETCH granted in N, so the response in N+1 is a NOP.
  - Flush_D in cycle N+1 also forces NOP on that cycle's response.
  - Flush_D never affects data responses.
- With Stall_En=1, fetch is never granted and Stall_Fetch=0; data is still served.
- Stall_Fetch and Stall_Mem are combinational from the same-cycle requests and Starve_Cnt.

## Test plan
- Fetch only:
  - Stimulus: F_Req=1 with F_Addr stepping 0,4,8.
  - Required: Instr equals memory words 0,1,2 one cycle after each address; F_Valid=1; Stall_Fetch=0.
- Contention:
  - Stimulus: load D_Addr=0x100 and fetch F_Addr=0x10 in the same cycle.
  - Required: M_Addr=0x100; Stall_Fetch=1; next cycle D_Done=1, D_R_Data=mem[0x100], Instr=0x00000013, F_Valid=0.
- Starvation with MAX_DATA_BURST=4:
  - Stimulus: D_Req and F_Req held high for 6 cycles.
  - Required: grants DATA×4, FETCH, DATA; Stall_Mem=1 only in cycle 5.
- Store then load to the same address:
  - Stimulus: store 0xDEADBEEF to 0x200 (D_W_En=1), then load 0x200.
  - Required: M_W_En high only in the store cycle; D_R_Data=0xDEADBEEF.
- Flush and stall:
  - Flush_D with a fetch granted gives Instr=0x00000013, F_Valid=0 in the next cycle.
  - Stall_En=1 gives no fetch grant and Stall_Fetch=0.
- Reset mid-access:
  - Stimulus: RST asserted in the cycle after a load is granted.
  - Required: D_Done=0 and F_Valid=0 in the following cycle; Starve_Cnt=0.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between fetch and the memory stage,
// data first with a bounded starvation guard for fetch, and steers responses back.
module memory_port_arbiter #(
    parameter int          MAX_DATA_BURST = 4,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        F_Req,
    input  logic [31:0] F_Addr,
    input  logic        Stall_En,
    input  logic        Flush_D,
    input  logic        D_Req,
    input  logic        D_W_En,
    input  logic [2:0]  D_Control,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_W_Data,
    output logic [31:0] M_Addr,
    output logic        M_W_En,
    output logic [2:0]  M_Control,
    output logic [31:0] M_W_Data,
    input  logic [31:0] M_R_Data,
    output logic [31:0] Instr,
    output logic        F_Valid,
    output logic [31:0] D_R_Data,
    output logic        D_Done,
    output logic        Stall_Fetch,
    output logic        Stall_Mem
);
    localparam int CW = $clog2(MAX_DATA_BURST + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t        state;
    logic          kill;
    logic          load;
    logic [CW-1:0] starve_cnt;
    logic          f_elig;
    logic          full;
    logic          g_fetch;
    logic          g_data;

    always_comb begin
        f_elig      = F_Req && !Stall_En;
        full        = starve_cnt == CW'(MAX_DATA_BURST);
        g_fetch     = !RST && f_elig && (full || !D_Req);
        g_data      = !RST && D_Req && !(full && f_elig);
        M_Addr      = g_data ? D_Addr : g_fetch ? F_Addr : '0;
        M_W_En      = g_data && D_W_En;
        M_Control   = g_data ? D_Control : g_fetch ? 3'b010 : 3'b000;
        M_W_Data    = g_data ? D_W_Data : '0;
        Stall_Fetch = !RST && f_elig && !g_fetch;
        Stall_Mem   = !RST && D_Req && !g_data;
        // responses of an access in flight at reset are dropped
        F_Valid     = !RST && state == FETCH && !kill && !Flush_D;
        Instr       = F_Valid ? M_R_Data : NOP_INSTR;
        D_Done      = !RST && state == DATA;
        D_R_Data    = (D_Done && load) ? M_R_Data : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            kill       <= 1'b0;
            load       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= g_data ? DATA : g_fetch ? FETCH : IDLE;
            kill       <= g_fetch && Flush_D;
            load       <= g_data && !D_W_En;
            starve_cnt <= (g_fetch || !f_elig) ? '0 :
                          (g_data && !full) ? starve_cnt + 1'b1 : starve_cnt;
        end
    end
endmodule
